vga_frame_timing: RTL

//  Frame/line sequencer feeding the VGA-to-AXI bridge. Pops 8-bit pixels from a first-word-fall-through
//  (FWFT) FIFO and emits them as a VGA-style stream with inter-line and inter-frame blanking.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/vga_blank_cnt.sv | 35 +++
 rtl/vga_frame_timing.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types and constants for the VGA frame timing block.
//   state_t      : frame sequencer states
//   DIM_W/PIX_W  : line/column counter width and pixel width
//   *_BLANK_DEF  : default blanking lengths in clock cycles
//   max_int()    : helper used to size the shared blank counter
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } state_t;

  localparam int DIM_W       = 11;
  localparam int PIX_W       = 8;
  localparam int H_BLANK_DEF = 16;
  localparam int V_BLANK_DEF = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vga_blank_cnt.sv
// Blanking interval counter, shared by line and frame blanking.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : interval length in cycles (>=1)
//   dec        : count down while in a blanking state
//   done       : high during the last cycle of the interval
module vga_blank_cnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // The interval starts with cnt=load_val, so cnt==1 is its final cycle.
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/vga_frame_timing.sv
// Frame/line sequencer: pops pixels from a FWFT FIFO and emits them as a
// VGA-style valid/ready stream with inter-line and inter-frame blanking.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : start/continue frames (sampled in IDLE and at frame end)
//   width, height  : active pixels per line / lines per frame (latched)
//   pix_in         : FIFO head data, pix_empty : FIFO empty, pix_rd : FIFO pop
//   TREADY         : downstream ready
//   DATA_EN, pixel : output valid and data (held until accepted)
//   H_SYNC         : low on the last pixel of a line
//   V_SYNC         : low on the first pixel of a frame
//   busy           : sequencer not idle
// Build option: define VGA_TESTPAT_EN to replace the FIFO with an internal
// (x+y) test pattern; timing and syncs are unchanged.
module vga_frame_timing
  import vga_timing_pkg::*;
#(
  parameter int H_BLANK = H_BLANK_DEF,
  parameter int V_BLANK = V_BLANK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_empty,
  output logic             pix_rd,
  input  logic             TREADY,
  output logic             DATA_EN,
  output logic [PIX_W-1:0] pixel,
  output logic             H_SYNC,
  output logic             V_SYNC,
  output logic             busy
);

  localparam int CNT_W = $clog2(max_int(H_BLANK, V_BLANK) + 1);

  state_t           state, state_nxt;
  logic [DIM_W-1:0] x, y, w_m1, h_m1;
  logic             start_ok, last_x, last_y, first_px;
  logic             can_load, accept, frame_start;
  logic             src_valid;
  logic [PIX_W-1:0] src_pix;
  logic             cnt_load, cnt_dec, blank_done;
  logic [CNT_W-1:0] cnt_val;

  assign start_ok = enable && (width != '0) && (height != '0);
  assign last_x   = (x == w_m1);
  assign last_y   = (y == h_m1);
  assign first_px = (x == '0) && (y == '0);
  assign accept   = DATA_EN && TREADY;
  // Load only when the output register is empty or being drained this cycle.
  assign can_load = (state == ACTIVE) && src_valid && (!DATA_EN || TREADY);
  assign busy     = (state != IDLE);

`ifdef VGA_TESTPAT_EN
  logic unused_src;
  assign src_pix    = PIX_W'(x + y);
  assign src_valid  = 1'b1;
  assign pix_rd     = 1'b0;
  assign unused_src = ^{pix_in, pix_empty};
`else
  assign src_pix   = pix_in;
  assign src_valid = !pix_empty;
  assign pix_rd    = can_load;
`endif

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  // NOTE: async reset here only touches control flops; there are no
  // memories in this block that would need (or tolerate) a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (can_load && last_x) begin
          cnt_load = 1'b1;
          if (last_y) begin
            state_nxt = VBLANK;
            cnt_val   = CNT_W'(V_BLANK);
          end else begin
            state_nxt = HBLANK;
            cnt_val   = CNT_W'(H_BLANK);
          end
        end
      end
      HBLANK: begin
        if (blank_done) state_nxt = ACTIVE;
      end
      VBLANK: begin
        if (blank_done) state_nxt = start_ok ? ACTIVE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_dec     = (state == HBLANK) || (state == VBLANK);
  assign frame_start = ((state == IDLE) && start_ok) ||
                       ((state == VBLANK) && blank_done && start_ok);

  vga_blank_cnt #(
    .CNT_W(CNT_W)
  ) u_blank_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (cnt_dec),
    .done    (blank_done)
  );

  // ---------------------------------------------------------------------
  // Position counters and frame geometry latch
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      w_m1 <= '0;
      h_m1 <= '0;
    end else if (frame_start) begin
      x    <= '0;
      y    <= '0;
      w_m1 <= width - DIM_W'(1);
      h_m1 <= height - DIM_W'(1);
    end else begin
      if (can_load) x <= last_x ? '0 : x + DIM_W'(1);
      if ((state == HBLANK) && blank_done) y <= y + DIM_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Output register: holds pixel and syncs stable while TREADY is low
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DATA_EN <= 1'b0;
      pixel   <= '0;
      H_SYNC  <= 1'b1;
      V_SYNC  <= 1'b1;
    end else if (can_load) begin
      DATA_EN <= 1'b1;
      pixel   <= src_pix;
      H_SYNC  <= !last_x;
      V_SYNC  <= !first_px;
    end else if (accept) begin
      DATA_EN <= 1'b0;
      H_SYNC  <= 1'b1;
      V_SYNC  <= 1'b1;
    end
  end

endmodule
